// File: rtl/jt51_mixacc_pkg.sv
// Shared types and helpers for the jt51 operator accumulator / stereo mixer.
// Holds the phase and state encodings, carrier decode and a width-generic saturator.
package jt51_mixacc_pkg;

    typedef enum logic [1:0] {
        PH_M1 = 2'd0,
        PH_M2 = 2'd1,
        PH_C1 = 2'd2,
        PH_C2 = 2'd3
    } phase_e;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_RUN      = 1'b1
    } state_e;

    // Working width for saturation; callers sign-extend into it and slice back out.
    localparam int SAT_W = 64;

    // Which phases feed the channel output for each connection algorithm.
    function automatic logic is_carrier(input logic [2:0] con, input phase_e ph);
        case (ph)
            PH_M1:   is_carrier = (con == 3'd7);
            PH_M2:   is_carrier = (con >= 3'd5);
            PH_C1:   is_carrier = (con >= 3'd4);
            default: is_carrier = 1'b1;
        endcase
    endfunction

    // Clamp x to the signed range of a w-bit value (w < SAT_W).
    function automatic logic signed [SAT_W-1:0] sat_s(input logic signed [SAT_W-1:0] x,
                                                      input int unsigned w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi)      sat_s = hi;
        else if (x < lo) sat_s = lo;
        else             sat_s = x;
    endfunction

endpackage

// File: rtl/jt51_mixacc_chsh.sv
// CH-deep signed shift register holding one running accumulator per channel.
// The head entry is reloaded or saturating-accumulated with din_i and pushed back in.
module jt51_mixacc_chsh
    import jt51_mixacc_pkg::*;
#(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cen_i,
    input  logic                load_i,
    input  logic                acc_i,
    input  logic signed [W-1:0] din_i,
    output logic signed [W-1:0] next_o
);

    logic signed [W-1:0]     sh_q [DEPTH];
    logic signed [W-1:0]     head;
    logic signed [SAT_W-1:0] head_w;
    logic signed [SAT_W-1:0] din_w;
    logic signed [SAT_W-1:0] sum_w;

    assign head = sh_q[DEPTH-1];

    always_comb begin
        head_w = {{(SAT_W-W){head[W-1]}}, head};
        din_w  = {{(SAT_W-W){din_i[W-1]}}, din_i};
        sum_w  = sat_s(head_w + din_w, W);
        if (load_i)
            next_o = acc_i ? din_i : '0;
        else if (acc_i)
            next_o = sum_w[W-1:0];
        else
            next_o = head;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: this array is reset because accumulators must read 0 after reset;
            // large RAM-style memories normally stay unreset so they map to block RAM.
            for (int i = 0; i < DEPTH; i++)
                sh_q[i] <= '0;
        end else if (cen_i) begin
            sh_q[0] <= next_o;
            for (int i = 1; i < DEPTH; i++)
                sh_q[i] <= sh_q[i-1];
        end
    end

endmodule

// File: rtl/jt51_mixacc.sv
// Time-multiplexed operator accumulator and stereo mixer: one saturated L/R sample per frame.
// Optional per-channel tap enabled by defining JT51_MIXACC_CHOUT_EN.
module jt51_mixacc
    import jt51_mixacc_pkg::*;
#(
    parameter int CH   = 8,
    parameter int OPS  = 4,
    parameter int OPW  = 14,
    parameter int ACCW = 16,
    parameter int OUTW = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cen,
    input  logic                   frame_start,
    input  logic [2:0]             con,
    input  logic [1:0]             rl,
    input  logic signed [OPW-1:0]  op_in,
    output logic signed [OUTW-1:0] left,
    output logic signed [OUTW-1:0] right,
    output logic                   out_valid
`ifdef JT51_MIXACC_CHOUT_EN
    ,
    output logic signed [ACCW-1:0]   ch_out,
    output logic [$clog2(CH)-1:0]    ch_idx,
    output logic                     ch_valid
`endif
);

    localparam int CHW   = $clog2(CH);
    localparam int SLOTS = OPS * CH;
    localparam int CW    = $clog2(SLOTS);
    localparam int MIXW  = ACCW + CHW;

    state_e                  state_q;
    logic [CW-1:0]           cnt_q;
    logic signed [MIXW-1:0]  mixl_q, mixr_q;
    logic signed [OUTW-1:0]  left_q, right_q;
    logic                    out_valid_q;

    logic                    active;
    logic                    last;
    logic                    carrier;
    logic [CW-1:0]           cnt_eff;
    phase_e                  phase;
    logic [CHW-1:0]          chan;
    logic signed [ACCW-1:0]  din;
    logic signed [ACCW-1:0]  v;
    logic signed [MIXW-1:0]  v_ext;
    logic signed [MIXW-1:0]  mixl_d, mixr_d;
    logic signed [SAT_W-1:0] left_w, right_w;
    logic signed [OUTW-1:0]  left_d, right_d;

    // A frame_start slot always counts as slot 0, whether locking or resynchronising.
    always_comb begin
        // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
        cnt_eff = frame_start ? '0 : cnt_q;
        active  = cen && (frame_start || (state_q == ST_RUN));
        last    = (cnt_eff == CW'(SLOTS - 1));
        phase   = phase_e'(cnt_eff[CW-1:CHW]);
        chan    = cnt_eff[CHW-1:0];
        carrier = is_carrier(con, phase);
        din     = {{(ACCW-OPW){op_in[OPW-1]}}, op_in};
    end

    jt51_mixacc_chsh #(
        .W     (ACCW),
        .DEPTH (CH)
    ) u_chsh (
        .clk    (clk),
        .rst    (rst),
        .cen_i  (active),
        .load_i (phase == PH_M1),
        .acc_i  (carrier),
        .din_i  (din),
        .next_o (v)
    );

    // Partial sums are dropped on frame_start; only phase C2 slots contribute.
    always_comb begin
        v_ext  = {{CHW{v[ACCW-1]}}, v};
        mixl_d = frame_start ? '0 : mixl_q;
        mixr_d = frame_start ? '0 : mixr_q;
        if (phase == PH_C2) begin
            if (rl[0]) mixl_d = mixl_d + v_ext;
            if (rl[1]) mixr_d = mixr_d + v_ext;
        end
        left_w  = sat_s({{(SAT_W-MIXW){mixl_d[MIXW-1]}}, mixl_d}, OUTW);
        right_w = sat_s({{(SAT_W-MIXW){mixr_d[MIXW-1]}}, mixr_d}, OUTW);
        left_d  = left_w[OUTW-1:0];
        right_d = right_w[OUTW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_UNLOCKED;
            cnt_q       <= '0;
            mixl_q      <= '0;
            mixr_q      <= '0;
            left_q      <= '0;
            right_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (active) begin
                state_q <= ST_RUN;
                cnt_q   <= cnt_eff + 1'b1;
                if (last) begin
                    left_q      <= left_d;
                    right_q     <= right_d;
                    mixl_q      <= '0;
                    mixr_q      <= '0;
                    out_valid_q <= 1'b1;
                end else begin
                    mixl_q <= mixl_d;
                    mixr_q <= mixr_d;
                end
            end
        end
    end

    assign left      = left_q;
    assign right     = right_q;
    assign out_valid = out_valid_q;

`ifdef JT51_MIXACC_CHOUT_EN
    logic signed [ACCW-1:0] ch_out_q;
    logic [CHW-1:0]         ch_idx_q;
    logic                   ch_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_out_q   <= '0;
            ch_idx_q   <= '0;
            ch_valid_q <= 1'b0;
        end else begin
            ch_valid_q <= 1'b0;
            if (active && (phase == PH_C2)) begin
                ch_out_q   <= v;
                ch_idx_q   <= chan;
                ch_valid_q <= 1'b1;
            end
        end
    end

    assign ch_out   = ch_out_q;
    assign ch_idx   = ch_idx_q;
    assign ch_valid = ch_valid_q;
`endif

endmodule
